// File: rtl/pattern_detector.sv
// -----------------------------------------------------------------------------
// pattern_detector
//
// Programmable serial bit-pattern detector. A pattern of PAT_LEN bits is loaded
// at run time. Qualified serial bits are then shifted into a history register
// and compared against that pattern. A registered one-cycle pulse marks each
// match. Overlapping and non-overlapping matching are both supported, and a
// saturating counter keeps a running total of matches.
//
// Parameters
//   PAT_LEN      pattern length in bits (2..32)
//   CNT_W        width of the match counter
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   load         capture pattern_in and arm the detector
//   pattern_in   pattern; bit PAT_LEN-1 is the first bit expected on the stream
//   overlap      1 = overlapping matches, 0 = non-overlapping
//   i_valid      qualifies i
//   i            serial data bit
//   clear_count  zero the match counter (wins over a same-cycle increment)
//   armed        high once a pattern has been loaded
//   o            registered one-cycle match pulse
//   match_count  saturating match count
// -----------------------------------------------------------------------------
module pattern_detector #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [PAT_LEN-1:0] pattern_in,
    input  logic               overlap,
    input  logic               i_valid,
    input  logic               i,
    input  logic               clear_count,
    output logic               armed,
    output logic               o,
    output logic [CNT_W-1:0]   match_count
);

    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        UNARMED = 1'b0,
        ARMED   = 1'b1
    } state_t;

    state_t               state_r, state_s;
    logic [PAT_LEN-1:0]   pat_r, pat_s;
    logic [PAT_LEN-1:0]   hist_r, hist_s;
    logic [FILL_W-1:0]    fill_r, fill_s;
    logic                 o_r, o_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;

    logic [PAT_LEN-1:0]   hist_n_s;
    logic [FILL_W-1:0]    fill_n_s;
    logic                 match_s;

    // Next-state, datapath and counter update logic.
    always_comb begin
        state_s  = state_r;
        pat_s    = pat_r;
        hist_s   = hist_r;
        fill_s   = fill_r;
        o_s      = 1'b0;
        cnt_s    = cnt_r;
        match_s  = 1'b0;
        // Candidate history/fill if the current bit is accepted; fill saturates
        // at PAT_LEN so it only tells us whether the window is full.
        hist_n_s = {hist_r[PAT_LEN-2:0], i};
        if (fill_r == FILL_FULL) begin
            fill_n_s = fill_r;
        end else begin
            fill_n_s = fill_r + {{(FILL_W-1){1'b0}}, 1'b1};
        end

        case (state_r)
            UNARMED: begin
                if (load) begin
                    state_s = ARMED;
                    pat_s   = pattern_in;
                    hist_s  = {PAT_LEN{1'b0}};
                    fill_s  = {FILL_W{1'b0}};
                end else begin
                    state_s = UNARMED;
                end
            end
            ARMED: begin
                // load wins over i_valid: the bit presented with load is dropped
                if (load) begin
                    pat_s  = pattern_in;
                    hist_s = {PAT_LEN{1'b0}};
                    fill_s = {FILL_W{1'b0}};
                end else if (i_valid) begin
                    hist_s  = hist_n_s;
                    match_s = (fill_n_s == FILL_FULL) && (hist_n_s == pat_r);
                    o_s     = match_s;
                    // Non-overlap: a match restarts the window so the next
                    // match needs PAT_LEN fresh bits.
                    if (match_s && !overlap) begin
                        fill_s = {FILL_W{1'b0}};
                    end else begin
                        fill_s = fill_n_s;
                    end
                end else begin
                    hist_s = hist_r;
                    fill_s = fill_r;
                end
            end
            default: begin
                state_s = UNARMED;
            end
        endcase

        if (clear_count) begin
            cnt_s = {CNT_W{1'b0}};
        end else if (match_s && (cnt_r != CNT_MAX)) begin
            cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_s = cnt_r;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= UNARMED;
            pat_r   <= {PAT_LEN{1'b0}};
            hist_r  <= {PAT_LEN{1'b0}};
            fill_r  <= {FILL_W{1'b0}};
            o_r     <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            pat_r   <= pat_s;
            hist_r  <= hist_s;
            fill_r  <= fill_s;
            o_r     <= o_s;
            cnt_r   <= cnt_s;
        end
    end

    assign armed       = (state_r == ARMED);
    assign o           = o_r;
    assign match_count = cnt_r;

endmodule

// File: tb/tb_pattern_detector.sv
// -----------------------------------------------------------------------------
// tb_pattern_detector
//
// Drives two detector instances (PAT_LEN=4/CNT_W=8 and PAT_LEN=2/CNT_W=2) with
// the same stimulus and compares every cycle against a behavioural model that
// tracks the accepted bit stream as an integer and a window length.
// -----------------------------------------------------------------------------
module tb_pattern_detector;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [31:0] pat_in = 32'd0;
    logic        overlap = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_bit = 1'b0;
    logic        clear_count = 1'b0;

    logic        armed_a, o_a;
    logic [7:0]  cnt_a;
    logic        armed_b, o_b;
    logic [1:0]  cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state, index 0 = instance a, 1 = instance b
    int          plen [2] = '{4, 2};
    int          cmax [2] = '{255, 3};
    bit          m_armed [2];
    longint      m_pat [2];
    longint      m_val [2];
    int          m_win [2];
    int          m_cnt [2];
    bit          m_o [2];

    pattern_detector #(.PAT_LEN(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .load(load), .pattern_in(pat_in[3:0]),
        .overlap(overlap), .i_valid(i_valid), .i(i_bit),
        .clear_count(clear_count), .armed(armed_a), .o(o_a), .match_count(cnt_a)
    );

    pattern_detector #(.PAT_LEN(2), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .load(load), .pattern_in(pat_in[1:0]),
        .overlap(overlap), .i_valid(i_valid), .i(i_bit),
        .clear_count(clear_count), .armed(armed_b), .o(o_b), .match_count(cnt_b)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: one clock edge for instance k using the currently driven inputs
    task automatic model_edge(input int k);
        longint mask;
        mask = (64'd1 << plen[k]) - 64'd1;
        if (rst) begin
            m_armed[k] = 1'b0; m_pat[k] = 0; m_val[k] = 0;
            m_win[k] = 0; m_cnt[k] = 0; m_o[k] = 1'b0;
        end else begin
            m_o[k] = 1'b0;
            if (load) begin
                m_armed[k] = 1'b1;
                m_pat[k]   = longint'(pat_in) & mask;
                m_val[k]   = 0;
                m_win[k]   = 0;
            end else if (m_armed[k] && i_valid) begin
                m_val[k] = ((m_val[k] * 2) + longint'(i_bit)) & 64'hFFFF_FFFF;
                m_win[k] = m_win[k] + 1;
                if (m_win[k] >= plen[k] && ((m_val[k] & mask) == m_pat[k])) begin
                    m_o[k] = 1'b1;
                    if (!overlap) m_win[k] = 0;
                end
            end
            if (clear_count) m_cnt[k] = 0;
            else if (m_o[k] && m_cnt[k] < cmax[k]) m_cnt[k] = m_cnt[k] + 1;
        end
    endtask

    // One cycle: drive inputs, take the edge, update model, compare outputs
    task automatic cyc(input logic r, input logic ld, input logic [31:0] p,
                       input logic ov, input logic v, input logic b, input logic clr);
        rst = r; load = ld; pat_in = p; overlap = ov;
        i_valid = v; i_bit = b; clear_count = clr;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_eq("armed_a", armed_a, m_armed[0]);
        check_eq("o_a",     o_a,     m_o[0]);
        check_eq("cnt_a",   cnt_a,   m_cnt[0]);
        check_eq("armed_b", armed_b, m_armed[1]);
        check_eq("o_b",     o_b,     m_o[1]);
        check_eq("cnt_b",   cnt_b,   m_cnt[1]);
    endtask

    task automatic do_rst();
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_load(input logic [31:0] p, input logic ov);
        cyc(1'b0, 1'b1, p, ov, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send(input logic b, input logic ov);
        cyc(1'b0, 1'b0, 32'd0, ov, 1'b1, b, 1'b0);
    endtask

    task automatic idle(input logic ov);
        cyc(1'b0, 1'b0, 32'd0, ov, 1'b0, 1'b0, 1'b0);
    endtask

    logic [6:0] stream7;

    initial begin
        stream7 = 7'b1101101;

        // Reset, then stream 1101 while unarmed
        do_rst();
        check_eq("rst_armed", armed_a, 32'd0);
        check_eq("rst_cnt", cnt_a, 32'd0);
        send(1'b1, 1'b1); send(1'b1, 1'b1); send(1'b0, 1'b1); send(1'b1, 1'b1);
        idle(1'b1);
        check_eq("unarmed_cnt", cnt_a, 32'd0);
        check_eq("unarmed_armed", armed_a, 32'd0);

        // Overlap on: pulses after bit 4 and bit 7
        do_rst();
        do_load(32'hD, 1'b1);
        check_eq("armed_after_load", armed_a, 32'd1);
        for (int k = 6; k >= 0; k--) begin
            send(stream7[k], 1'b1);
            if (k == 3 || k == 0) check_eq("ovl_pulse", o_a, 32'd1);
        end
        check_eq("ovl_cnt", cnt_a, 32'd2);

        // Overlap off: single pulse after bit 4
        do_rst();
        do_load(32'hD, 1'b0);
        for (int k = 6; k >= 0; k--) begin
            send(stream7[k], 1'b0);
            if (k == 0) check_eq("novl_no_pulse", o_a, 32'd0);
        end
        check_eq("novl_cnt", cnt_a, 32'd1);

        // Gaps between bits, then reload with a same-cycle valid bit
        do_rst();
        do_load(32'hD, 1'b1);
        for (int k = 3; k >= 0; k--) begin
            send(stream7[k + 3], 1'b1);
            if (k == 0) check_eq("gap_pulse", o_a, 32'd1);
            for (int g = 0; g < 3; g++) idle(1'b1);
        end
        check_eq("gap_cnt", cnt_a, 32'd1);
        cyc(1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("reload_cnt", cnt_a, 32'd1);
        for (int k = 0; k < 4; k++) send(1'b0, 1'b1);
        check_eq("reload_pulse", o_a, 32'd1);
        check_eq("reload_cnt2", cnt_a, 32'd2);

        // Saturation on the 2-bit instance, then clear with a match
        do_rst();
        do_load(32'h3, 1'b1);
        for (int k = 0; k < 6; k++) send(1'b1, 1'b1);
        check_eq("sat_cnt", cnt_b, 32'd3);
        check_eq("sat_pulse", o_b, 32'd1);
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        check_eq("clr_cnt", cnt_b, 32'd0);
        check_eq("clr_pulse", o_b, 32'd1);

        // Reset mid-operation
        do_rst();
        do_load(32'hD, 1'b1);
        send(1'b1, 1'b1); send(1'b1, 1'b1); send(1'b0, 1'b1);
        do_rst();
        send(1'b1, 1'b1);
        check_eq("mid_rst_o", o_a, 32'd0);
        check_eq("mid_rst_armed", armed_a, 32'd0);
        check_eq("mid_rst_cnt", cnt_a, 32'd0);

        // Randomised traffic against the model
        do_rst();
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 39) == 0),
                32'($urandom_range(0, 15)),
                ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 9) < 7),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 49) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_detector.md
# pattern_detector

Parametrised, programmable serial bit-pattern detector, the generalised successor to the fixed four-bit sequence detectors in the lab designs. It accepts a qualified serial bit stream and compares it against a run-time loadable pattern of `PAT_LEN` bits. It supports overlapping and non-overlapping match modes, produces a registered one-cycle match pulse, and keeps a saturating match counter. It sits between a serial input front end and any consumer that needs match events or match statistics.

## Interface
- `PAT_LEN`, default 4: pattern length in bits; legal range 2..32.
- `CNT_W`, default 8: width of the match counter.
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `load`  input  1  capture `pattern_in` and arm the detector.
- `pattern_in`  input  PAT_LEN  pattern; bit `PAT_LEN-1` is the first bit expected on the stream.
- `overlap`  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
- `i_valid`  input  1  qualifies `i`; a bit is consumed only when high.
- `i`  input  1  serial data bit.
- `clear_count`  input  1  zero the match counter.
- `armed`  output  1  high once a pattern has been loaded.
- `o`  output  1  registered match pulse.
- `match_count`  output  CNT_W  saturating count of matches.

## Operation
- **States**
  - `UNARMED`: the state after reset. Input bits are ignored and `o` = 0.
  - `ARMED`: bits are consumed and compared.
  - Transitions: `UNARMED` goes to `ARMED` on `load`. `ARMED` stays in `ARMED`; a further `load` re-arms with the new pattern. Only `rst` returns the block to `UNARMED`.
- **Registers**
  - `pat` [PAT_LEN]
  - `hist` [PAT_LEN]: the newest bit is at the LSB.
  - `fill`: counts 0..PAT_LEN; width is clog2(PAT_LEN+1).
- **On `load`**
  - `pat` <= `pattern_in`, `hist` <= 0, `fill` <= 0, `o` <= 0.
  - `load` has priority over `i_valid` in the same cycle, so the bit presented that cycle is dropped.
- **On an accepted bit** (`ARMED` && `i_valid` && !`load`)
  - hist_n = {hist[PAT_LEN-2:0], i}.
  - fill_n = min(fill+1, PAT_LEN).
  - match = (fill_n == PAT_LEN) && (hist_n == pat).
  - `hist` <= hist_n. `o` <= match.
  - If match && !`overlap`, then `fill` <= 0, so the next match needs PAT_LEN fresh bits. Otherwise `fill` <= fill_n.
- **Cycles with `i_valid` = 0**: `hist` and `fill` hold and `o` <= 0.
- **`overlap`** is sampled on the edge that completes a match. Changing it mid-stream takes effect on the next match.
- **`match_count`**
  - Increments by 1 on each cycle where match = 1.
  - Saturates at 2^CNT_W−1 and never wraps.
  - `clear_count` has priority over increment: a simultaneous match leaves the count at 0, but `o` still pulses.
- **Partial matches** carry no state beyond `hist`. Detection is exact: a match is reported at every stream position where the last PAT_LEN accepted bits equal `pat` (subject to the overlap rule).

## Timing
- **Reset**: on the first edge with `rst` = 1, `armed` = 0, `o` = 0, `match_count` = 0, `pat` = 0, `hist` = 0, `fill` = 0, and the state is `UNARMED`.
  - `rst` has priority over every other input, including `load`.
  - Reset mid-stream discards the pattern; a new `load` is required.
- **`armed`** goes high in the cycle after the `load` edge.
- **`o` latency**: `o` is high for the single cycle following the edge that samples the completing bit, and is low in every other cycle. Back-to-back pulses occur only when consecutive accepted bits each complete a match; for example, all-ones pattern and stream in overlap mode.
- **`match_count`** updates on the same edge that raises `o`.
- **First bit after load**: the earliest possible match is on the PAT_LEN-th accepted bit after the `load` edge.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- **Reset and unarmed**:
  - Stimulus: assert `rst`, then stream 1101 with no `load`.
  - Required: `armed` = 0, `o` never high, `match_count` = 0.
- **Overlap on**:
  - Stimulus: PAT_LEN=4, load 4'b1101, `overlap` = 1, stream 1,1,0,1,1,0,1.
  - Required: `o` pulses after bit 4 and after bit 7; `match_count` = 2.
- **Overlap off**:
  - Stimulus: same stream as above with `overlap` = 0.
  - Required: a single pulse after bit 4; `match_count` = 1.
- **Gaps and reload**:
  - Stimulus: load 4'b1101, stream 1,1,0,1 with `i_valid` low for 3 cycles between every bit.
  - Required: one pulse, one cycle after the final valid bit.
  - Stimulus: then load 4'b0000 in the same cycle as an `i_valid` = 1 bit.
  - Required: that bit is dropped; `match_count` holds at 1; the next four zeros produce a pulse and the count becomes 2.
- **Saturation and clear**:
  - Stimulus: CNT_W=2, load 2'b11 with PAT_LEN=2, `overlap` = 1, stream 6 ones.
  - Required: pulses after bits 2..6; `match_count` stops at 3.
  - Stimulus: `clear_count` in the same cycle as a match.
  - Required: count = 0 and `o` = 1.
- **Reset mid-operation**:
  - Stimulus: after 3 bits of 1101, assert `rst` for one cycle, then stream 1.
  - Required: no pulse, `armed` = 0, `match_count` = 0.
